// File: rtl/program_loader.sv
// Host-side loader for the stack-machine processor: streams a program into its memory,
// appends a halt if missing, starts it and returns the result word with a status code.
module program_loader #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 16,
  parameter int                TIMEOUT   = 65535,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'hC000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              p_wr,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_datain,
  output logic              p_start,
  input  logic              p_ready,
  input  logic [DATA_W-1:0] p_out,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        status,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CAP   = 2 ** ADDR_W;
  localparam int CYC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_APPEND, S_SETTLE, S_START, S_WAIT_BUSY, S_RUN, S_DRAIN, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_TIMEOUT  = 2'd1,
    ST_OVERFLOW = 2'd2
  } status_t;

  state_t           state, state_n;
  logic [ADDR_W:0]  cnt;
  logic [ADDR_W:0]  cnt_inc;
  logic [CYC_W-1:0] cyc;
  logic [1:0]       wait_cnt;
  logic             retried;
  logic             accept;
  logic             is_halt;
  logic             at_last_addr;
  logic             loading;

  // DRAIN is overflow discard mode: it takes words without needing the processor.
  assign loading      = (state == S_IDLE) || (state == S_LOAD);
  assign in_ready     = (loading && p_ready) || (state == S_DRAIN);
  assign accept       = in_valid && in_ready;
  assign is_halt      = (in_data[DATA_W-1 -: 2] == 2'b11);
  assign cnt_inc      = cnt + 1'b1;
  assign at_last_addr = (cnt == (ADDR_W+1)'(CAP - 1));
  assign p_start      = (state == S_START);
  assign done         = (state == S_DONE);

  // NOTE: every path through an always_comb block must assign each target, so the
  // default goes first; a missing branch would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          if (in_last) begin
            if (is_halt)                          state_n = S_SETTLE;
            else if (cnt_inc < (ADDR_W+1)'(CAP))  state_n = S_APPEND;
            else                                  state_n = S_DONE;
          end else if (at_last_addr) begin
            state_n = S_DRAIN;
          end else begin
            state_n = S_LOAD;
          end
        end
      end
      S_APPEND:    state_n = S_SETTLE;
      S_SETTLE:    state_n = S_START;
      S_START:     state_n = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!p_ready)               state_n = S_RUN;
        else if (wait_cnt == 2'd3)  state_n = retried ? S_DONE : S_START;
      end
      S_RUN: begin
        if (p_ready || (cyc == CYC_W'(TIMEOUT - 1))) state_n = S_DONE;
      end
      S_DRAIN: begin
        if (accept && in_last) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: the memory itself lives in the processor; every register here is small
  // control state, so all of it is cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      p_wr         <= 1'b0;
      p_addr       <= '0;
      p_datain     <= '0;
      result       <= '0;
      status       <= ST_OK;
      words_loaded <= '0;
      cnt          <= '0;
      cyc          <= '0;
      wait_cnt     <= '0;
      retried      <= 1'b0;
    end else begin
      state <= state_n;
      // NOTE: non-blocking assignment lets this default be overridden later in the
      // same block without creating an intermediate value other processes could see.
      p_wr  <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            p_wr         <= 1'b1;
            p_addr       <= cnt[ADDR_W-1:0];
            p_datain     <= in_data;
            cnt          <= cnt_inc;
            words_loaded <= cnt_inc;
            if (state_n == S_DONE) status <= ST_OVERFLOW;
          end
        end
        S_APPEND: begin
          p_wr         <= 1'b1;
          p_addr       <= cnt[ADDR_W-1:0];
          p_datain     <= HALT_WORD;
          cnt          <= cnt_inc;
          words_loaded <= cnt_inc;
        end
        S_SETTLE: retried  <= 1'b0;
        S_START:  wait_cnt <= '0;
        S_WAIT_BUSY: begin
          if (!p_ready) begin
            cyc <= '0;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
            if (state_n == S_START) retried <= 1'b1;
            if (state_n == S_DONE)  status  <= ST_TIMEOUT;
          end
        end
        S_RUN: begin
          cyc <= cyc + 1'b1;
          if (p_ready) begin
            result <= p_out;
            status <= ST_OK;
          end else if (state_n == S_DONE) begin
            result <= p_out;
            status <= ST_TIMEOUT;
          end
        end
        S_DRAIN: begin
          if (state_n == S_DONE) status <= ST_OVERFLOW;
        end
        S_DONE:  cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a small stack-machine stub stands in for the processor,
// and a stream-level model predicts every write, start count and completion record.
module tb_program_loader;

  localparam int          ADDR_W  = 10;
  localparam int          DATA_W  = 16;
  localparam int          TIMEOUT = 20;
  localparam int          CAP     = 1024;
  localparam logic [15:0] HALT    = 16'hC000;

  typedef logic [15:0] word_q_t[$];
  typedef struct packed { logic [9:0] addr; logic [15:0] data; } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic              p_wr;
  logic [ADDR_W-1:0] p_addr;
  logic [15:0]       p_datain;
  logic              p_start;
  logic              p_ready;
  logic [15:0]       p_out = '0;
  logic              done;
  logic [15:0]       result;
  logic [1:0]        status;
  logic [ADDR_W:0]   words_loaded;

  always #5 clk = ~clk;

  program_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .HALT_WORD(HALT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .p_wr(p_wr), .p_addr(p_addr), .p_datain(p_datain), .p_start(p_start),
    .p_ready(p_ready), .p_out(p_out),
    .done(done), .result(result), .status(status), .words_loaded(words_loaded)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Processor stub: push (00), op (10: 1=neg, 2=add, 7=jump 0), halt (11).
  logic [15:0] mem [CAP];
  logic [15:0] stk [16];
  logic [3:0]  sp = '0;
  logic [9:0]  pc = '0;
  logic        busy = 1'b0;
  logic        hold_busy = 1'b0;
  logic        ignore_start = 1'b0;
  logic        proc_rst = 1'b0;
  logic [15:0] ins;

  assign p_ready = !busy && !hold_busy;
  assign ins     = mem[pc];

  always @(posedge clk) begin
    if (p_wr) mem[p_addr] <= p_datain;
    if (proc_rst) begin
      busy <= 1'b0;
    end else if (p_start && !ignore_start) begin
      busy <= 1'b1;
      pc   <= '0;
      sp   <= '0;
    end else if (busy) begin
      case (ins[15:14])
        2'b11: begin busy <= 1'b0; p_out <= stk[sp - 4'd1]; end
        2'b00: begin stk[sp] <= {2'b00, ins[13:0]}; sp <= sp + 4'd1; pc <= pc + 10'd1; end
        2'b10: begin
          case (ins[2:0])
            3'd1: begin stk[sp - 4'd1] <= -stk[sp - 4'd1]; pc <= pc + 10'd1; end
            3'd2: begin
              stk[sp - 4'd2] <= stk[sp - 4'd2] + stk[sp - 4'd1];
              sp <= sp - 4'd1;
              pc <= pc + 10'd1;
            end
            3'd7:    pc <= '0;
            default: pc <= pc + 10'd1;
          endcase
        end
        default: pc <= pc + 10'd1;
      endcase
    end
  end

  // Expected behaviour of the loader, derived from the word list alone.
  wr_t             exp_wr[$];
  wr_t             cur_wr;
  logic [1:0]      exp_status = '0;
  logic [15:0]     exp_result = '0;
  logic [ADDR_W:0] exp_wl = '0;
  int              exp_starts = 0;
  bit              check_timing = 1'b0;

  task automatic expect_program(input word_q_t prog, input logic [15:0] res);
    int n;
    bit halted;
    n      = prog.size();
    halted = (prog[n-1][15:14] == 2'b11);
    for (int i = 0; i < n && i < CAP; i++) exp_wr.push_back('{addr: 10'(i), data: prog[i]});
    exp_result = res;
    if (n > CAP || (n == CAP && !halted)) begin
      exp_status = 2'd2;
      exp_wl     = (ADDR_W+1)'(CAP);
      exp_starts = 0;
    end else begin
      if (!halted) exp_wr.push_back('{addr: 10'(n), data: HALT});
      exp_status = 2'd0;
      exp_wl     = (ADDR_W+1)'(n + (halted ? 0 : 1));
      exp_starts = 1;
    end
  endtask

  int   cyc_n = 0;
  int   fall_cyc = 0;
  int   done_seen = 0;
  int   start_seen = 0;
  logic prev_ready = 1'b1;

  always @(negedge clk) begin
    cyc_n++;
    if (prev_ready && !p_ready) fall_cyc = cyc_n;
    prev_ready = p_ready;
    if (p_wr === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("p_wr_unexpected", 32'(p_wr), 32'd0);
      end else begin
        cur_wr = exp_wr.pop_front();
        check("p_addr", 32'(p_addr), 32'(cur_wr.addr));
        check("p_datain", 32'(p_datain), 32'(cur_wr.data));
      end
    end
    if (p_start === 1'b1) start_seen++;
    if (done === 1'b1) begin
      done_seen++;
      check("done_status", 32'(status), 32'(exp_status));
      check("done_words_loaded", 32'(words_loaded), 32'(exp_wl));
      if (exp_status == 2'd0) check("done_result", 32'(result), 32'(exp_result));
      if (check_timing) check("run_cycles", 32'(cyc_n - fall_cyc - 1), 32'(TIMEOUT));
    end
  end

  task automatic send_stream(input word_q_t prog, input bit mark_last);
    for (int i = 0; i < prog.size(); i++) begin
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_data  = prog[i];
      in_last  = mark_last && (i == prog.size() - 1);
      for (int k = 0; k < 50 && !acc; k++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) check("accept_timeout", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_seen;
    for (int k = 0; k < budget && done_seen == d0; k++) @(posedge clk);
    #1;
    check({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
  endtask

  task automatic run_test(input word_q_t prog, input logic [15:0] res, input string tag);
    int s0 = start_seen;
    expect_program(prog, res);
    send_stream(prog, 1'b1);
    wait_done(200, tag);
    check({tag, "_starts"}, 32'(start_seen - s0), 32'(exp_starts));
    check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_q_t p;
    int      s0;
    int      d0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_p_wr", 32'(p_wr), 32'd0);
    check("rst_p_start", 32'(p_start), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Program ending in halt: 3 + 4
    p = '{16'h0003, 16'h0004, 16'h8002, 16'hC000};
    run_test(p, 16'h0007, "t1");
    check("t1_result", 32'(result), 32'h7);
    check("t1_status", 32'(status), 32'd0);
    check("t1_words_loaded", 32'(words_loaded), 32'd4);

    // Missing halt gets appended: -5
    p = '{16'h0005, 16'h8001};
    run_test(p, 16'hFFFB, "t2");
    check("t2_result", 32'(result), 32'hFFFB);
    check("t2_words_loaded", 32'(words_loaded), 32'd3);

    // Endless loop runs into the cycle limit
    p = '{16'h0000, 16'h8007};
    s0 = start_seen;
    expect_program(p, 16'h0000);
    exp_status   = 2'd1;
    check_timing = 1'b1;
    send_stream(p, 1'b1);
    wait_done(200, "t3");
    check_timing = 1'b0;
    check("t3_status", 32'(status), 32'd1);
    check("t3_starts", 32'(start_seen - s0), 32'd1);
    in_valid = 1'b1;
    in_data  = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_in_ready_busy", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    proc_rst = 1'b1;
    @(posedge clk); #1;
    proc_rst = 1'b0;
    @(negedge clk);
    check("t3_in_ready_free", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 1025 words: last one dropped, overflow, no start
    p = {};
    for (int i = 0; i < CAP + 1; i++) p.push_back(16'(i & 16'h3FFF));
    run_test(p, 16'h0000, "t4");
    check("t4_status", 32'(status), 32'd2);
    check("t4_words_loaded", 32'(words_loaded), 32'd1024);

    // Processor never leaves ready: one retry, then timeout status
    ignore_start = 1'b1;
    p = '{16'h0001, 16'hC000};
    s0 = start_seen;
    expect_program(p, 16'h0000);
    exp_status = 2'd1;
    exp_starts = 2;
    send_stream(p, 1'b1);
    wait_done(100, "t5");
    check("t5_starts", 32'(start_seen - s0), 32'd2);
    check("t5_status", 32'(status), 32'd1);
    ignore_start = 1'b0;

    // Processor busy in IDLE: nothing accepted until it is ready again
    hold_busy = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0009;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_in_ready_held", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    p = '{16'h0009, 16'hC000};
    expect_program(p, 16'h0009);
    hold_busy = 1'b0;
    @(negedge clk);
    check("t6_in_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("t6_first_addr", 32'(p_addr), 32'd0);
    check("t6_first_wr", 32'(p_wr), 32'd1);
    p = '{16'hC000};
    send_stream(p, 1'b1);
    wait_done(200, "t6");
    check("t6_result", 32'(result), 32'h9);

    // Reset during the third word aborts silently
    d0 = done_seen;
    exp_wr.push_back('{addr: 10'd0, data: 16'h0001});
    exp_wr.push_back('{addr: 10'd1, data: 16'h0002});
    p = '{16'h0001, 16'h0002};
    send_stream(p, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h0003;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t7_p_wr", 32'(p_wr), 32'd0);
    check("t7_p_addr", 32'(p_addr), 32'd0);
    check("t7_p_datain", 32'(p_datain), 32'd0);
    check("t7_p_start", 32'(p_start), 32'd0);
    check("t7_result", 32'(result), 32'd0);
    check("t7_words_loaded", 32'(words_loaded), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t7_no_done", 32'(done_seen - d0), 32'd0);
    p = '{16'h0006, 16'h0007, 16'h8002, 16'hC000};
    run_test(p, 16'h000D, "t7");
    check("t7_result_after", 32'(result), 32'hD);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
